imem_loader: RTL

- Boot-time writer for the instruction memory. The core's fetch path only reads that memory; this block fills it.
- Accepts a byte stream (e.g. from a UART receiver) on a valid/ready handshake.
- Assembles little-endian 32-bit instruction words and drives a write port: byte address WA, data WD, strobe WE. The memory indexes words by WA[31:2].
- Holds the core in reset while a load is in progress.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_byte_packer.sv | 39 +++
 rtl/imem_loader.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional checksum byte is enabled with the IMEM_LOADER_CHECKSUM_EN macro.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN0  = 3'd1,
    LEN1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6,
    CHK   = 3'd7
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_ADDR_STEP = 4;
  localparam int HDR_LEN_W      = 16;

endpackage

// File: rtl/imem_byte_packer.sv
// Little-endian byte-to-word assembler: first accepted byte lands in bits [7:0].
module imem_byte_packer
  import imem_loader_pkg::*;
#(
  parameter int W = 8 * BYTES_PER_WORD
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         accept_i,
  input  logic [7:0]   byte_i,
  output logic [W-1:0] word_o,
  output logic         word_ready_o
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  logic [IDX_W-1:0] idx_q;
  logic [W-1:0]     word_q;

  // Shifting in from the top leaves the oldest byte at the bottom after a full word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (clear_i) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (accept_i) begin
      idx_q  <= idx_q + IDX_W'(1);
      word_q <= {byte_i, word_q[W-1:8]};
    end
  end

  assign word_o       = word_q;
  assign word_ready_o = accept_i && (idx_q == LAST_IDX);

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: length header, LE word stream, core held in reset.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int N         = 32,
  parameter int ENTRIES   = 265,
  parameter int LEN_BYTES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [7:0]   in_byte,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         WE,
  output logic [N-1:0] WA,
  output logic [N-1:0] WD,
  output logic         cpu_rst_n,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int LEN_W = LEN_BYTES * 8;
  localparam int PW    = 8 * BYTES_PER_WORD;
  localparam logic [N-1:0] ADDR_STEP = N'(WORD_ADDR_STEP);

  state_e                 state_q, state_d;
  logic [7:0]             len_lo_q, len_lo_d;
  logic [HDR_LEN_W-1:0]   rem_q, rem_d;
  logic [N-1:0]           ptr_q, ptr_d;
  logic [7:0]             csum_q, csum_d;
  logic                   in_ready_q, we_q, busy_q, done_q, err_q, cpu_rst_n_q;

  logic                   xfer, launch, pk_accept, pk_ready;
  logic [LEN_W-1:0]       hdr_len;
  logic [PW-1:0]          pk_word;

  assign xfer      = in_valid && in_ready_q;
  assign launch    = start && (state_q == IDLE || state_q == DONE || state_q == ERR);
  assign pk_accept = xfer && (state_q == DATA);
  assign hdr_len   = {in_byte, len_lo_q};

  imem_byte_packer #(.W(PW)) u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (launch),
    .accept_i     (pk_accept),
    .byte_i       (in_byte),
    .word_o       (pk_word),
    .word_ready_o (pk_ready)
  );

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    rem_d    = rem_q;
    ptr_d    = ptr_q;
    csum_d   = csum_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LEN0;
          ptr_d   = '0;
          csum_d  = '0;
        end
      end
      LEN0: begin
        if (xfer) begin
          len_lo_d = in_byte;
          state_d  = LEN1;
        end
      end
      LEN1: begin
        if (xfer) begin
          rem_d = HDR_LEN_W'(hdr_len);
          if (hdr_len == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = DONE;
`endif
          end else if (32'(hdr_len) > ENTRIES) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          csum_d = csum_q ^ in_byte;
          if (pk_ready) state_d = WRITE;
        end
      end
      WRITE: begin
        rem_d = rem_q - HDR_LEN_W'(1);
        // Pointer stays on the last written word so it never passes the memory end.
        if (rem_q == HDR_LEN_W'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end else begin
          ptr_d   = ptr_q + ADDR_STEP;
          state_d = DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (xfer) state_d = (in_byte == csum_q) ? DONE : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      len_lo_q <= '0;
      rem_q    <= '0;
      ptr_q    <= '0;
      csum_q   <= '0;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      rem_q    <= rem_d;
      ptr_q    <= ptr_d;
      csum_q   <= csum_d;
    end
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b1;
    end else begin
      in_ready_q  <= (state_d == LEN0) || (state_d == LEN1) ||
                     (state_d == DATA) || (state_d == CHK);
      we_q        <= (state_d == WRITE);
      busy_q      <= (state_d != IDLE) && (state_d != DONE) && (state_d != ERR);
      done_q      <= (state_d == DONE);
      err_q       <= (state_d == ERR);
      cpu_rst_n_q <= (state_d == IDLE) || (state_d == DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign WE        = we_q;
  assign WA        = ptr_q;
  assign WD        = N'(pk_word);
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cpu_rst_n = cpu_rst_n_q;

endmodule
